// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank: register indices, bus source encodings
// and register widths.
package register_bank_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;
  localparam int IO_W       = 8;
  localparam int NUM_REGS   = 8;

  localparam int REG_AR   = 0;
  localparam int REG_PC   = 1;
  localparam int REG_DR   = 2;
  localparam int REG_AC   = 3;
  localparam int REG_IR   = 4;
  localparam int REG_TR   = 5;
  localparam int REG_OUTR = 6;
  localparam int REG_INPR = 7;

  typedef enum logic [2:0] {
    BUS_ZERO = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

endpackage

// File: rtl/register_bank_bank_reg.sv
// Single bank register of parameterised width: clear beats load beats increment.
module bank_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         inr,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
    else if (inr) q <= q + W'(1);
  end

endmodule

// File: rtl/register_bank.sv
// Eight-register bank with a common bus. Define REGBANK_CONFLICT_EN to build the
// sticky err flag for multiple strobes on one register; otherwise err is tied 0.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ld,
  input  logic [7:0]        inr,
  input  logic [7:0]        clr,
  input  logic [2:0]        bus_sel,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        inpr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] bus,
  output logic [15:0]       ir,
  output logic [DATA_W-1:0] ac,
  output logic [7:0]        outr,
  output logic              err
);

  logic [ADDR_W-1:0] ar_q, pc_q;
  logic [DATA_W-1:0] dr_q, ac_q, ir_q, tr_q;
  logic [IO_W-1:0]   outr_q, inpr_q;
  logic              unused_inpr;

  // Bus is driven from pre-edge register values, so a register loading from
  // itself simply holds (read-before-write).
  always_comb begin
    bus = '0;
    unique case (bus_sel_e'(bus_sel))
      BUS_ZERO: bus = '0;
      BUS_AR:   bus = DATA_W'(ar_q);
      BUS_PC:   bus = DATA_W'(pc_q);
      BUS_DR:   bus = dr_q;
      BUS_AC:   bus = ac_q;
      BUS_IR:   bus = ir_q;
      BUS_TR:   bus = tr_q;
      BUS_MEM:  bus = mem_rdata;
      default:  bus = '0;
    endcase
  end

  bank_reg #(.W(ADDR_W)) u_ar (
    .clk(clk), .reset(reset), .ld(ld[REG_AR]), .inr(inr[REG_AR]), .clr(clr[REG_AR]),
    .d(bus[ADDR_W-1:0]), .q(ar_q));

  bank_reg #(.W(ADDR_W)) u_pc (
    .clk(clk), .reset(reset), .ld(ld[REG_PC]), .inr(inr[REG_PC]), .clr(clr[REG_PC]),
    .d(bus[ADDR_W-1:0]), .q(pc_q));

  bank_reg #(.W(DATA_W)) u_dr (
    .clk(clk), .reset(reset), .ld(ld[REG_DR]), .inr(inr[REG_DR]), .clr(clr[REG_DR]),
    .d(bus), .q(dr_q));

  bank_reg #(.W(DATA_W)) u_ac (
    .clk(clk), .reset(reset), .ld(ld[REG_AC]), .inr(inr[REG_AC]), .clr(clr[REG_AC]),
    .d(bus), .q(ac_q));

  bank_reg #(.W(DATA_W)) u_ir (
    .clk(clk), .reset(reset), .ld(ld[REG_IR]), .inr(inr[REG_IR]), .clr(clr[REG_IR]),
    .d(bus), .q(ir_q));

  bank_reg #(.W(DATA_W)) u_tr (
    .clk(clk), .reset(reset), .ld(ld[REG_TR]), .inr(inr[REG_TR]), .clr(clr[REG_TR]),
    .d(bus), .q(tr_q));

  bank_reg #(.W(IO_W)) u_outr (
    .clk(clk), .reset(reset), .ld(ld[REG_OUTR]), .inr(inr[REG_OUTR]), .clr(clr[REG_OUTR]),
    .d(bus[IO_W-1:0]), .q(outr_q));

  // INPR is fed from the external input byte, never from the bus.
  bank_reg #(.W(IO_W)) u_inpr (
    .clk(clk), .reset(reset), .ld(ld[REG_INPR]), .inr(inr[REG_INPR]), .clr(clr[REG_INPR]),
    .d(inpr_data), .q(inpr_q));

  assign unused_inpr = ^inpr_q;

  assign mem_addr = ar_q;
  assign ir       = 16'(ir_q);
  assign ac       = ac_q;
  assign outr     = outr_q;

`ifdef REGBANK_CONFLICT_EN
  logic [7:0] conflict;
  logic       err_q;

  assign conflict = (ld & inr) | (ld & clr) | (inr & clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         err_q <= 1'b0;
    else if (|conflict) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank; expected values are hand-computed.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ld, inr, clr;
  logic [2:0]  bus_sel;
  logic [15:0] mem_rdata;
  logic [7:0]  inpr_data;
  logic [11:0] mem_addr;
  logic [15:0] bus;
  logic [15:0] ir;
  logic [15:0] ac;
  logic [7:0]  outr;
  logic        err;

  int errors = 0;
  int checks = 0;

`ifdef REGBANK_CONFLICT_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  register_bank dut (
    .clk(clk), .reset(reset), .ld(ld), .inr(inr), .clr(clr), .bus_sel(bus_sel),
    .mem_rdata(mem_rdata), .inpr_data(inpr_data), .mem_addr(mem_addr), .bus(bus),
    .ir(ir), .ac(ac), .outr(outr), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ld  = '0;
    inr = '0;
    clr = '0;
  endtask

  // Load a register from mem_rdata through the bus.
  task automatic load_mem(input int idx, input logic [15:0] val);
    bus_sel   = 3'd7;
    mem_rdata = val;
    ld[idx]   = 1'b1;
    tick();
  endtask

  task automatic peek(input logic [2:0] sel, input string tag, input logic [15:0] exp);
    bus_sel = sel;
    #1;
    check(tag, {16'h0, bus}, {16'h0, exp});
  endtask

  initial begin
    reset = 1'b0; ld = '0; inr = '0; clr = '0;
    bus_sel = 3'd0; mem_rdata = 16'h0; inpr_data = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    check("rst_ac", {16'h0, ac}, 32'h0);
    check("rst_ir", {16'h0, ir}, 32'h0);
    check("rst_outr", {24'h0, outr}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    peek(3'd2, "rst_pc", 16'h0000);
    reset = 1'b1;

    // Fetch path
    load_mem(1, 16'h0005);
    peek(3'd2, "pc_load", 16'h0005);
    bus_sel = 3'd2; ld[0] = 1'b1;
    tick();
    check("fetch_ar", {20'h0, mem_addr}, 32'h005);
    bus_sel = 3'd7; mem_rdata = 16'h7123; ld[4] = 1'b1; inr[1] = 1'b1;
    tick();
    check("fetch_ir", {16'h0, ir}, 32'h7123);
    peek(3'd2, "fetch_pc_inc", 16'h0006);
    peek(3'd5, "bus_ir", 16'h7123);

    // Wrap-around
    load_mem(3, 16'hFFFF);
    check("ac_ffff", {16'h0, ac}, 32'hFFFF);
    inr[3] = 1'b1;
    tick();
    check("ac_wrap", {16'h0, ac}, 32'h0000);
    load_mem(1, 16'hFFFF);
    peek(3'd2, "pc_trunc", 16'h0FFF);
    inr[1] = 1'b1;
    tick();
    peek(3'd2, "pc_wrap", 16'h0000);

    // Truncation and read-before-write
    load_mem(3, 16'hABCD);
    bus_sel = 3'd4; ld[0] = 1'b1; ld[6] = 1'b1; ld[3] = 1'b1;
    tick();
    check("trunc_ar", {20'h0, mem_addr}, 32'hBCD);
    check("trunc_outr", {24'h0, outr}, 32'hCD);
    check("rbw_ac", {16'h0, ac}, 32'hABCD);
    peek(3'd1, "bus_ar_zext", 16'h0BCD);
    check("err_before_conflict", {31'h0, err}, 32'h0);

    // INPR loads from inpr_data even with a different bus value
    load_mem(2, 16'h1111);
    peek(3'd3, "dr_load", 16'h1111);
    inpr_data = 8'h5A; bus_sel = 3'd3; ld[7] = 1'b1;
    tick();
    check("inpr_load", {24'h0, dut.u_inpr.q}, 32'h5A);
    check("inpr_outr_hold", {24'h0, outr}, 32'hCD);
    peek(3'd0, "bus_zero", 16'h0000);
    mem_rdata = 16'h3C3C;
    peek(3'd7, "bus_mem", 16'h3C3C);

    // Priority clr > ld > inr
    load_mem(5, 16'h1234);
    peek(3'd6, "tr_load", 16'h1234);
    bus_sel = 3'd7; mem_rdata = 16'h5555;
    clr[5] = 1'b1; ld[5] = 1'b1; inr[5] = 1'b1;
    tick();
    peek(3'd6, "prio_clr", 16'h0000);
    check("err_set", {31'h0, err}, {31'h0, ERR_EXP});
    bus_sel = 3'd7; mem_rdata = 16'h0042; ld[2] = 1'b1; inr[2] = 1'b1;
    tick();
    peek(3'd3, "prio_ld_over_inr", 16'h0042);
    tick();
    check("err_sticky", {31'h0, err}, {31'h0, ERR_EXP});

    // Asynchronous reset mid-run with a pending strobe
    inr[3] = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ac", {16'h0, ac}, 32'h0);
    check("async_rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    check("async_rst_ir", {16'h0, ir}, 32'h0);
    check("async_rst_outr", {24'h0, outr}, 32'h0);
    check("async_rst_err", {31'h0, err}, 32'h0);
    check("async_rst_inpr", {24'h0, dut.u_inpr.q}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_ac", {16'h0, ac}, 32'h0);
    reset = 1'b1;
    inr[3] = 1'b1;
    tick();
    check("post_rst_inr", {16'h0, ac}, 32'h0001);
    check("post_rst_err", {31'h0, err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus/memory data width.
REQ-002 SHALL have parameter ADDR_W, default 12, width of AR and PC.
REQ-003 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: ld  input  8  per-register load strobe from control unit.
REQ-006 SHALL have ports: inr  input  8  per-register increment strobe.
REQ-007 SHALL have ports: clr  input  8  per-register clear strobe.
REQ-008 SHALL have ports: bus_sel  input  3  common-bus source select.
REQ-009 SHALL have ports: mem_rdata  input  DATA_W  memory read data; mem_addr  output  ADDR_W  equals AR; bus  output  DATA_W  current common-bus value.
REQ-010 SHALL have ports: inpr_data  input  8  external input byte; ir  output  16  IR contents to control unit; ac  output  DATA_W; outr  output  8.
REQ-011 SHALL have port err  output  1  sticky control-conflict flag (only with REGBANK_CONFLICT_EN; tied 0 otherwise).

Function
REQ-012 Register index map SHALL be: 0 AR(ADDR_W), 1 PC(ADDR_W), 2 DR, 3 AC, 4 IR, 5 TR (all DATA_W), 6 OUTR(8), 7 INPR(8).
REQ-013 bus_sel SHALL select combinationally: 0 zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 mem_rdata; narrower sources zero-extended.
REQ-014 Each register SHALL update on rising clk with priority clr > ld > inr; no strobe -> hold.
REQ-015 ld SHALL load bus truncated to register width (AR/PC take bus[ADDR_W-1:0], OUTR takes bus[7:0]); INPR ld SHALL load inpr_data, not bus.
REQ-016 inr SHALL add 1 modulo 2^width; AR/PC 0xFFF -> 0x000, DR/AC/IR/TR 0xFFFF -> 0x0000, OUTR/INPR 0xFF -> 0x00.
REQ-017 Loaded/incremented value SHALL be visible on outputs and bus one cycle after the strobe (latency 1); bus itself has zero latency.
REQ-018 Loading register N while bus_sel selects register N SHALL capture the pre-edge value (read-before-write).
REQ-019 Strobes to different registers in the same cycle SHALL all take effect independently.
REQ-020 mem_addr SHALL equal AR at all times; ir, ac, outr SHALL be direct register outputs.

Reset
REQ-021 reset low SHALL immediately clear all eight registers and err to 0 regardless of clk.
REQ-022 Reset asserted mid-operation SHALL discard any in-flight strobe; first update occurs on the first rising clk after reset deasserts.

Configuration
REQ-023 Macro REGBANK_CONFLICT_EN defined: err SHALL set on the rising clk where any register index has two or more of ld/inr/clr asserted, and stay set until reset; priority rule REQ-014 still applies.
REQ-024 Macro REGBANK_CONFLICT_EN undefined: no conflict logic SHALL be built; err SHALL be constant 0.

Structure
REQ-025 Shared package SHALL hold register index constants (AR..INPR), bus_sel encodings, and register width constants.
REQ-026 One sub-module SHALL be used: bank_reg, a parameterised-width register with ld/inr/clr, instantiated eight times.

Verification
REQ-027 Reset: drive reset low mid-run -> all outputs 0 and err 0 the same cycle.
REQ-028 Fetch path: PC=0x005, bus_sel=2, ld[0]=1 -> AR=0x005; then bus_sel=7, mem_rdata=0x7123, ld[4]=1, inr[1]=1 -> IR=0x7123, PC=0x006.
REQ-029 Wrap: AC=0xFFFF, inr[3]=1 -> AC=0x0000; PC=0xFFF, inr[1]=1 -> PC=0x000.
REQ-030 Priority: TR=0x1234, clr[5]=ld[5]=inr[5]=1 -> TR=0x0000; with REGBANK_CONFLICT_EN err=1 and stays 1; without, err=0.
REQ-031 Truncation and read-before-write: AC=0xABCD, bus_sel=4, ld[0]=ld[6]=ld[3]=1 -> AR=0xBCD, OUTR=0xCD, AC=0xABCD.
REQ-032 INPR: inpr_data=0x5A, bus_sel=3, ld[7]=1 -> INPR=0x5A, independent of bus.
